imem_boot_ctrl: RTL and testbench
=================================

# imem_boot_ctrl

Boot-load and fetch controller for the single-cycle core's 64-word instruction memory. After reset it holds the core stalled and streams a program into the instruction RAM over a valid/ready port, one word per handshake. It then hands the memory's read port to the core's PC-driven fetch path. It sits between the program loader (UART/testbench stream) and the instruction memory, replacing hard-coded `initial` ROM contents with a run-time load.

## Interface
- `DEPTH`, 64: number of 32-bit instruction words.
- `AW`, 6: word-address width; must equal log2(`DEPTH`).

- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `load_req` input 1: request a reload; sampled only in RUN.
- `s_data` input 32: program word.
- `s_valid` input 1: `s_data` is valid.
- `s_last` input 1: final word of the program; qualified by `s_valid`.
- `s_ready` output 1: controller accepts a word this cycle.
- `fetch_addr` input 32: core PC, byte address.
- `fetch_instr` output 32: instruction returned to the core.
- `core_hold` output 1: stall/hold the core; high whenever the state is not RUN.
- `mem_addr` output AW: instruction RAM word address.
- `mem_wdata` output 32: RAM write data.
- `mem_we` output 1: RAM write enable.
- `mem_rdata` input 32: RAM asynchronous read data.
- `load_done` output 1: one-cycle pulse on entry to RUN.
- `load_count` output AW+1: number of words written by the last completed load.
- `err_overflow` output 1: sticky; the load filled `DEPTH` words without `s_last`.
- `err_misalign` output 1: combinational, `fetch_addr[1:0] != 0` while in RUN.

## Operation
- States: CLEAR (only with macro), LOAD, RUN. The reset state is CLEAR if the macro is defined, otherwise LOAD.
- **LOAD**
  - `s_ready`=1, `core_hold`=1, `mem_addr`=`wptr`, `mem_wdata`=`s_data`, `mem_we`=`s_valid`.
  - On each handshake, `wptr` increments.
  - The state goes to RUN on a handshake with `s_last`=1, or on the handshake that writes word `DEPTH-1`.
  - If that final word had `s_last`=0, set `err_overflow`.
  - On the exit handshake, `load_count` is set to `wptr`+1.
- **RUN**
  - `s_ready`=0, `core_hold`=0, `mem_we`=0, `mem_addr`=`fetch_addr[AW+1:2]`.
  - `fetch_instr`=`mem_rdata` if `fetch_addr[31:AW+2]`==0; otherwise `fetch_instr`=0x00000013 (NOP).
  - `load_req`=1 moves the state to LOAD (or to CLEAR with the macro) and clears `wptr` and `err_overflow`.
  - `load_count` holds its value until the next load completes.
- **Outside RUN**, `fetch_instr`=0x00000013.
- `s_valid` with `s_ready`=0 is ignored; nothing is written.
- `load_req` in LOAD or CLEAR is ignored, including in the same cycle as the final handshake.

## Timing
- Reset values:
  - state = CLEAR or LOAD, `wptr`=0, `load_count`=0, `err_overflow`=0, `load_done`=0.
  - `core_hold`=1, `mem_we`=0.
  - `s_ready`=1 without the macro, 0 with it.
- The RAM write commits on the handshake edge; there is zero cycles of handshake latency.
- Final handshake at edge N: state=RUN and `load_done`=1 during cycle N+1; `core_hold` falls in that same cycle.
- `load_req` high at edge N: `core_hold`=1 from cycle N+1.
- Fetch is combinational (address to instruction in the same cycle), matching the single-cycle core.
- `reset_n` asserted mid-load aborts immediately: `wptr`=0, and the load restarts from word 0 after release. Partially written RAM contents are left as-is.
- `wptr` never wraps. A stream longer than `DEPTH` is cut off because `s_ready` drops in RUN.

## Configuration
- Macro: `IMEM_BOOT_CLEAR_EN`.
- **Defined:**
  - Entering a load passes through CLEAR, which writes 0x00000013 to words 0..`DEPTH-1`, one per cycle (`mem_we`=1, `s_ready`=0, `core_hold`=1).
  - CLEAR lasts `DEPTH` cycles, then goes to LOAD with `wptr`=0.
  - Unloaded words therefore execute as NOP.
- **Undefined:** there is no CLEAR state; unloaded words keep stale contents.

## Test plan
- Reset, then stream 4 words (0x004182B3, 0x409403B3, 0x00000013, 0x00C30413; `s_last` on the 4th) → RAM[0..3] written; `load_done` pulses once; `load_count`=4; `core_hold`=0; `fetch_addr`=0x4 returns 0x409403B3.
- In RUN, `fetch_addr`=0x100 → `fetch_instr`=0x00000013. `fetch_addr`=0x6 → `err_misalign`=1.
- Stream 64 words with no `s_last` → RUN after word 63; `err_overflow`=1; `load_count`=64. A 65th `s_valid` is not accepted.
- In RUN, pulse `load_req`, then load 2 words → `core_hold`=1 from the next cycle; `err_overflow` clears; `load_count`=2.
- Drop `reset_n` after 3 of 5 words, then reload all 5 → writes restart at address 0; `load_count`=5.
- With `IMEM_BOOT_CLEAR_EN` defined: `s_ready`=0 for exactly 64 cycles after reset, then load 1 word → RAM[1..63]=0x00000013.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Boot-load/fetch controller for the 64-word instruction RAM: streams a program in over valid/ready,
// then gives the RAM read port to the core. Macro IMEM_BOOT_CLEAR_EN adds a NOP pre-fill (CLEAR) pass.
module imem_boot_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_req,
    input  logic [31:0]   s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   fetch_instr,
    output logic          core_hold,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata,
    output logic          load_done,
    output logic [AW:0]   load_count,
    output logic          err_overflow,
    output logic          err_misalign
);
    localparam logic [31:0]   NOP       = 32'h0000_0013;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

`ifdef IMEM_BOOT_CLEAR_EN
    localparam state_t ENTRY = ST_CLEAR;
`else
    localparam state_t ENTRY = ST_LOAD;
`endif

    state_t          r_state;
    logic [AW-1:0]   r_wptr;
    logic [AW:0]     r_load_count;
    logic            r_err_overflow;
    logic            r_load_done;
    logic            w_run;
    logic            w_in_range;

    // r_wptr doubles as the fill pointer during CLEAR; it holds on load exit so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ENTRY;
            r_wptr         <= '0;
            r_load_count   <= '0;
            r_err_overflow <= 1'b0;
            r_load_done    <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
`ifdef IMEM_BOOT_CLEAR_EN
                ST_CLEAR: begin
                    if (r_wptr == LAST_ADDR) begin
                        r_state <= ST_LOAD;
                        r_wptr  <= '0;
                    end else begin
                        r_wptr <= r_wptr + AW'(1);
                    end
                end
`endif
                ST_LOAD: begin
                    if (s_valid) begin
                        if (s_last || (r_wptr == LAST_ADDR)) begin
                            r_state        <= ST_RUN;
                            r_load_done    <= 1'b1;
                            r_load_count   <= (AW+1)'(r_wptr) + (AW+1)'(1);
                            r_err_overflow <= ~s_last;
                        end else begin
                            r_wptr <= r_wptr + AW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (load_req) begin
                        r_state        <= ENTRY;
                        r_wptr         <= '0;
                        r_err_overflow <= 1'b0;
                    end
                end
                default: r_state <= ENTRY;
            endcase
        end
    end

    assign w_run      = (r_state == ST_RUN);
    assign w_in_range = (fetch_addr[31:AW+2] == '0);

    always_comb begin
        s_ready     = 1'b0;
        core_hold   = 1'b1;
        mem_addr    = r_wptr;
        mem_wdata   = s_data;
        mem_we      = 1'b0;
        fetch_instr = NOP;
        case (r_state)
`ifdef IMEM_BOOT_CLEAR_EN
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = NOP;
            end
`endif
            ST_LOAD: begin
                s_ready = 1'b1;
                mem_we  = s_valid;
            end
            ST_RUN: begin
                core_hold   = 1'b0;
                mem_addr    = fetch_addr[AW+1:2];
                fetch_instr = w_in_range ? mem_rdata : NOP;
            end
            default: ;
        endcase
    end

    assign err_misalign = w_run && (fetch_addr[1:0] != 2'b00);
    assign load_done    = r_load_done;
    assign load_count   = r_load_count;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: emulates the instruction RAM, keeps a load-level model of the
// controller (run flag, words taken, expected RAM image) and checks the DUT against it each cycle.
module tb_imem_boot_ctrl;
    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_BOOT_CLEAR_EN
    localparam int CLR_CYCLES = DEPTH;
`else
    localparam int CLR_CYCLES = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_req;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        core_hold;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        load_done;
    logic [6:0]  load_count;
    logic        err_overflow;
    logic        err_misalign;
    logic        tb_init;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    imem_boot_ctrl dut (
        .clk(clk), .reset_n(reset_n), .load_req(load_req),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .core_hold(core_hold),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .load_done(load_done), .load_count(load_count),
        .err_overflow(err_overflow), .err_misalign(err_misalign)
    );

    // Instruction RAM emulation: synchronous write, asynchronous read.
    logic [31:0] tb_ram [DEPTH];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < DEPTH; i++) tb_ram[i] <= 32'hBAD0_0000 | i;
        end else if (mem_we) begin
            tb_ram[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = tb_ram[mem_addr];

    // Load-level model: either running, or clearing/collecting words of a program.
    logic [31:0] exp_mem [DEPTH];
    bit m_run;
    int m_widx;
    int m_count;
    bit m_ovf;
    bit m_done;
    int m_clear;

    always @(posedge clk or negedge reset_n) begin
        if (tb_init) begin
            for (int i = 0; i < DEPTH; i++) exp_mem[i] <= 32'hBAD0_0000 | i;
        end else if (!reset_n) begin
            m_run   <= 1'b0;
            m_widx  <= 0;
            m_count <= 0;
            m_ovf   <= 1'b0;
            m_done  <= 1'b0;
            m_clear <= CLR_CYCLES;
        end else begin
            m_done <= 1'b0;
            if (m_run) begin
                if (load_req) begin
                    m_run   <= 1'b0;
                    m_widx  <= 0;
                    m_ovf   <= 1'b0;
                    m_clear <= CLR_CYCLES;
                end
            end else if (m_clear > 0) begin
                exp_mem[DEPTH - m_clear] <= NOP;
                m_clear <= m_clear - 1;
            end else if (s_valid) begin
                exp_mem[m_widx] <= s_data;
                m_widx <= m_widx + 1;
                if (s_last || m_widx == DEPTH - 1) begin
                    m_run   <= 1'b1;
                    m_done  <= 1'b1;
                    m_count <= m_widx + 1;
                    m_ovf   <= ~s_last;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n && !tb_init) begin
            logic [31:0] exp_fi;
            exp_fi = (m_run && fetch_addr[31:8] == 24'd0) ? exp_mem[fetch_addr[7:2]] : NOP;
            chk("core_hold",    {31'd0, core_hold},    {31'd0, !m_run});
            chk("s_ready",      {31'd0, s_ready},      {31'd0, (!m_run && m_clear == 0)});
            chk("mem_we",       {31'd0, mem_we},       {31'd0, m_run ? 1'b0 : (m_clear > 0 ? 1'b1 : s_valid)});
            chk("load_done",    {31'd0, load_done},    {31'd0, m_done});
            chk("load_count",   {25'd0, load_count},   m_count);
            chk("err_overflow", {31'd0, err_overflow}, {31'd0, m_ovf});
            chk("err_misalign", {31'd0, err_misalign}, {31'd0, (m_run && fetch_addr[1:0] != 2'b00)});
            chk("fetch_instr",  fetch_instr,           exp_fi);
        end
    end

    // Entered at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        s_data = d; s_valid = 1'b1; s_last = last;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        $display("send data=%08h last=%0b count=%0d", d, last, load_count);
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk("req_core_hold", {31'd0, core_hold}, 32'd1);
        chk("req_ovf_clear", {31'd0, err_overflow}, 32'd0);
        $display("load_req pulsed");
    endtask

    localparam logic [31:0] PROG [4] = '{32'h004182B3, 32'h409403B3, 32'h00000013, 32'h00C30413};

    initial begin
        logic [31:0] w;
        reset_n = 1'b0; tb_init = 1'b1; load_req = 1'b0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; fetch_addr = '0;
        repeat (2) @(posedge clk); #1 tb_init = 1'b0;
        repeat (2) @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
        chk("rst_s_ready",   {31'd0, s_ready},   (CLR_CYCLES == 0) ? 32'd1 : 32'd0);
        chk("rst_count",     {25'd0, load_count}, 32'd0);
        chk("rst_ovf",       {31'd0, err_overflow}, 32'd0);
        chk("rst_done",      {31'd0, load_done}, 32'd0);
        @(posedge clk); #1;

        // Four-word program
        for (int i = 0; i < 4; i++) begin
            w = PROG[i];
            send(w, i == 3);
        end
        @(negedge clk);
        chk("t1_done",  {31'd0, load_done}, 32'd1);
        chk("t1_hold",  {31'd0, core_hold}, 32'd0);
        chk("t1_count", {25'd0, load_count}, 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_ram", tb_ram[i], PROG[i]);
        @(posedge clk); #1;
        fetch_addr = 32'h4; #1;
        chk("t1_fetch4", fetch_instr, 32'h409403B3);
        @(negedge clk);
        chk("t1_done_once", {31'd0, load_done}, 32'd0);

        // Out-of-range and misaligned fetch
        @(posedge clk); #1;
        fetch_addr = 32'h100; #1;
        chk("t2_oor_nop", fetch_instr, NOP);
        fetch_addr = 32'h6; #1;
        chk("t2_misalign", {31'd0, err_misalign}, 32'd1);
        @(posedge clk); #1;
        fetch_addr = 32'h0;

        // 64 words without s_last
        pulse_req();
        for (int i = 0; i < DEPTH; i++) send(32'hA000_0000 + i, 1'b0);
        chk("t3_ovf",   {31'd0, err_overflow}, 32'd1);
        chk("t3_count", {25'd0, load_count}, 32'd64);
        chk("t3_run",   {31'd0, core_hold}, 32'd0);
        s_data = 32'hFFFF_FFFF; s_valid = 1'b1;
        @(negedge clk);
        chk("t3_65_ready", {31'd0, s_ready}, 32'd0);
        chk("t3_65_we",    {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("t3_65_ram0",  tb_ram[0], 32'hA000_0000);
        chk("t3_ram63",    tb_ram[63], 32'hA000_003F);

        // Reload of two words
        pulse_req();
        send(32'hB000_0000, 1'b0);
        send(32'hB000_0001, 1'b1);
        chk("t4_count", {25'd0, load_count}, 32'd2);
        chk("t4_ovf",   {31'd0, err_overflow}, 32'd0);
        chk("t4_ram0",  tb_ram[0], 32'hB000_0000);
        chk("t4_ram1",  tb_ram[1], 32'hB000_0001);
        chk("t4_ram2",  tb_ram[2], (CLR_CYCLES == 0) ? 32'hA000_0002 : NOP);

        // Reset mid-load, then full reload
        pulse_req();
        for (int i = 0; i < 3; i++) send(32'hC000_0000 + i, 1'b0);
        reset_n = 1'b0; #1;
        chk("t5_rst_hold",  {31'd0, core_hold}, 32'd1);
        chk("t5_rst_count", {25'd0, load_count}, 32'd0);
        repeat (2) @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) send(32'hC000_0000 + i, i == 4);
        chk("t5_count", {25'd0, load_count}, 32'd5);
        for (int i = 0; i < 5; i++) chk("t5_ram", tb_ram[i], 32'hC000_0000 + i);
        fetch_addr = 32'h10; #1;
        chk("t5_fetch10", fetch_instr, 32'hC000_0004);
        @(posedge clk); #1;
        fetch_addr = 32'h0;

`ifdef IMEM_BOOT_CLEAR_EN
        // One-word load after a clear pass
        pulse_req();
        send(32'hD000_0000, 1'b1);
        chk("t6_count", {25'd0, load_count}, 32'd1);
        chk("t6_ram0",  tb_ram[0], 32'hD000_0000);
        for (int i = 1; i < DEPTH; i++) chk("t6_ram_nop", tb_ram[i], NOP);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
